// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  // Counter width for a step count; one bit minimum so NIB=1 still has a register.
  function automatic int cnt_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_adder_cin.sv
// 4-bit adder slice with carry-in/carry-out; the single shared datapath.
module nibble_adder_cin
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequenced through one 4-bit adder, LS nibble first.
// Optional feature macro: SUBTRACT_EN (adds the Sub port and A-B support).
module nibble_serial_adder_ctrl
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start_Valid,
  output logic             Start_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SUBTRACT_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Done_Valid,
  input  logic             Done_Ready
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SUBTRACT_EN
  logic             sub_q, sub_d;
`endif

  logic [NIBBLE_W-1:0] a_nib, b_sel, b_nib, sum_nib;
  logic                cout;

  // Select the operand nibbles addressed by the step counter.
  always_comb begin
    a_nib = '0;
    b_sel = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = op_a_q[i*NIBBLE_W +: NIBBLE_W];
        b_sel = op_b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

`ifdef SUBTRACT_EN
  // Two's-complement subtract: invert B nibbles, initial carry of 1.
  assign b_nib = b_sel ^ {NIBBLE_W{sub_q}};
`else
  assign b_nib = b_sel;
`endif

  nibble_adder_cin u_add (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (sum_nib),
    .cout (cout)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef SUBTRACT_EN
    sub_d    = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start_Valid) begin
          op_a_d  = A;
          op_b_d  = B;
          cnt_d   = '0;
`ifdef SUBTRACT_EN
          sub_d   = Sub;
          carry_d = Sub;
`else
          carry_d = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) result_d[i*NIBBLE_W +: NIBBLE_W] = sum_nib;
        end
        carry_d = cout;
        if (cnt_q == CW'(NIB - 1)) state_d = DONE;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      DONE: begin
        if (Done_Ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; synchronous reset aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef SUBTRACT_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
`ifdef SUBTRACT_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign Start_Ready = (state_q == IDLE);
  assign Busy        = (state_q != IDLE);
  assign Done_Valid  = (state_q == DONE);
  assign Result      = result_q;
  assign Carry       = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16 and WIDTH=4).
module tb_nibble_serial_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
  } exp_t;

  logic         Clk = 1'b0;
  logic         Rst, Start_Valid, Done_Ready, Sub;
  logic [W-1:0] A, B;
  logic         Start_Ready, Busy, Carry, Done_Valid;
  logic [W-1:0] Result;

  logic       sv4, dr4, sub4;
  logic [3:0] a4, b4;
  logic       rdy4, busy4, c4, dv4;
  logic [3:0] r4;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 Clk = ~Clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start_Valid(Start_Valid), .Start_Ready(Start_Ready),
    .A(A), .B(B),
`ifdef SUBTRACT_EN
    .Sub(Sub),
`endif
    .Busy(Busy), .Result(Result), .Carry(Carry),
    .Done_Valid(Done_Valid), .Done_Ready(Done_Ready)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Start_Valid(sv4), .Start_Ready(rdy4),
    .A(a4), .B(b4),
`ifdef SUBTRACT_EN
    .Sub(sub4),
`endif
    .Busy(busy4), .Result(r4), .Carry(c4),
    .Done_Valid(dv4), .Done_Ready(dr4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: plain modular arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int unsigned ua = a;
    int unsigned ub = b;
    if (s) begin
      e.res = W'(ua - ub);
      e.c   = (ua >= ub);
    end else begin
      e.res = W'(ua + ub);
      e.c   = ((ua + ub) >= (32'd1 << W));
    end
    return e;
  endfunction

  // Monitor: compares every DONE cycle against the queue head, pops on handshake.
  always @(negedge Clk) begin
    if (!Rst && Done_Valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %0h with empty scoreboard", Result);
      end else begin
        chk("result", 32'(Result), 32'(exp_q[0].res));
        chk("carry", 32'(Carry), 32'(exp_q[0].c));
        if (Done_Ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int bp, input logic garbage);
    int n;
    @(posedge Clk); #1;
    Start_Valid = 1'b1; A = a; B = b; Sub = s;
    @(negedge Clk);
    chk("start_ready_idle", 32'(Start_Ready), 32'd1);
    exp_q.push_back(model(a, b, s));
    @(posedge Clk); #1;
    if (garbage) begin
      A = W'($urandom); B = W'($urandom); Sub = ~s;
    end else Start_Valid = 1'b0;
    n = 0;
    @(negedge Clk);
    while (!Done_Valid && n < 4 * NIB + 10) begin
      chk("start_ready_run", 32'(Start_Ready), 32'd0);
      chk("busy_run", 32'(Busy), 32'd1);
      @(negedge Clk);
      n++;
    end
    chk("latency", n, NIB);
    for (int i = 0; i < bp; i++) begin
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("done_held", 32'(Done_Valid), 32'd1);
      chk("start_ready_done", 32'(Start_Ready), 32'd0);
    end
    @(posedge Clk); #1;
    Start_Valid = 1'b0;
    Done_Ready  = 1'b1;
    @(posedge Clk); #1;
    Done_Ready = 1'b0;
    @(negedge Clk);
    chk("start_ready_after", 32'(Start_Ready), 32'd1);
    chk("done_valid_after", 32'(Done_Valid), 32'd0);
  endtask

  initial begin
    int n;
    logic s;
    Rst = 1'b1; Start_Valid = 1'b0; Done_Ready = 1'b0; A = '0; B = '0; Sub = 1'b0;
    sv4 = 1'b0; dr4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Start_Valid = 1'b1; A = 16'h1111; B = 16'h2222;
    @(negedge Clk);
    chk("rst_start_ready", 32'(Start_Ready), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done_valid", 32'(Done_Valid), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    chk("rst_carry", 32'(Carry), 32'd0);
    @(posedge Clk); #1;
    Start_Valid = 1'b0; Rst = 1'b0;
    @(negedge Clk);
    chk("rst_wins_busy", 32'(Busy), 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 3, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
`ifdef SUBTRACT_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b1, 0, 1'b1);
`endif
    for (int k = 0; k < 30; k++) begin
      s = 1'b0;
`ifdef SUBTRACT_EN
      s = 1'($urandom_range(1));
`endif
      run_op(W'($urandom), W'($urandom), s, int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    // Abort mid-RUN: Rst sampled at the edge ending the 2nd RUN cycle.
    @(posedge Clk); #1;
    Start_Valid = 1'b1; A = 16'hAAAA; B = 16'h5555; Sub = 1'b0;
    @(posedge Clk); #1;
    Start_Valid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    chk("abort_start_ready", 32'(Start_Ready), 32'd1);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done_valid", 32'(Done_Valid), 32'd0);
    chk("abort_result", 32'(Result), 32'd0);
    chk("abort_carry", 32'(Carry), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    // WIDTH=4 instance: single nibble step.
    @(posedge Clk); #1;
    sv4 = 1'b1; a4 = 4'h9; b4 = 4'h8;
    @(negedge Clk);
    chk("w4_ready", 32'(rdy4), 32'd1);
    @(posedge Clk); #1;
    sv4 = 1'b0;
    n = 0;
    @(negedge Clk);
    while (!dv4 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("w4_latency", n, 1);
    chk("w4_result", 32'(r4), 32'h1);
    chk("w4_carry", 32'(c4), 32'd1);
    @(posedge Clk); #1;
    dr4 = 1'b1;
    @(posedge Clk); #1;
    dr4 = 1'b0;
    @(negedge Clk);
    chk("w4_idle", 32'(busy4), 32'd0);

    repeat (3) @(posedge Clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequential controller that adds two WIDTH-bit operands by sequencing one shared 4-bit adder datapath, one nibble per cycle, least-significant nibble first. The ripple carry is held in a register between nibbles. Operands arrive and results leave through valid/ready handshakes. It sits between an operand producer and a result consumer wherever a wide add is needed but only one 4-bit adder slice is budgeted.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- NIB (localparam), WIDTH/4, number of nibble steps per operation.

Ports:
- Clk  input  1  sole clock; all state updates on its rising edge.
- Rst  input  1  reset; synchronous, active-high.
- Start_Valid  input  1  producer presents A/B (and Sub) this cycle.
- Start_Ready  output  1  controller can accept an operation.
- A  input  WIDTH  first operand, sampled on accept.
- B  input  WIDTH  second operand, sampled on accept.
- Sub  input  1  1 = A−B, 0 = A+B; exists only with SUBTRACT_EN, sampled on accept.
- Busy  output  1  an operation is in progress (RUN or DONE).
- Result  output  WIDTH  sum/difference, valid while Done_Valid=1.
- Carry  output  1  carry out of the MSB nibble, valid while Done_Valid=1.
- Done_Valid  output  1  Result/Carry are final.
- Done_Ready  input  1  consumer takes the result.

## Operation
- FSM states: IDLE, RUN, DONE. Registers: op_a, op_b, Result, carry_r, nibble counter cnt (width clog2(NIB), minimum 1).
- IDLE:
  - Start_Ready=1.
  - On Start_Valid && Start_Ready: latch A→op_a, B→op_b, Sub; clear cnt=0; set carry_r=0 (1 for subtract); go to RUN.
- RUN:
  - Each cycle: {c, s} = op_a[4cnt+3:4cnt] + b_nib + carry_r, where b_nib = op_b nibble (inverted for subtract).
  - Write s to Result[4cnt+3:4cnt]; c to carry_r; cnt = cnt+1.
  - When cnt == NIB−1, go to DONE instead of incrementing.
- DONE:
  - Done_Valid=1; Result and Carry (= carry_r) are held stable.
  - On Done_Ready=1: go to IDLE.
- Arithmetic is modulo 2^WIDTH.
- For subtract, Carry=1 means no borrow (A ≥ B unsigned).
- Start_Valid outside IDLE is ignored; operands are not queued.
- Result nibbles change only in RUN. Intermediate values are visible but meaningless while Done_Valid=0.
- Rst in any state (including mid-RUN) aborts the operation. All registers and outputs take their reset values; no partial result is reported.

## Timing
- Reset values:
  - State=IDLE.
  - Start_Ready=1.
  - Busy=0, Done_Valid=0.
  - Result=0, Carry=0, cnt=0, carry_r=0.
- Latency: accept at edge E0 → nibble i written at edge E(i+1) → Done_Valid=1 in the cycle after edge E(NIB), i.e. NIB cycles after accept.
- Throughput: at most one operation per NIB+2 cycles with Done_Ready tied high. There is no same-cycle DONE→accept bypass; Start_Ready rises the cycle after the Done_Ready handshake.
- Busy = (state != IDLE); Start_Ready = (state == IDLE). Both are registered-state decodes with no combinational path from inputs.
- Done_Ready low holds DONE indefinitely with outputs frozen.
- Rst asserted together with Start_Valid: reset wins and nothing is accepted.

## Configuration
- SUBTRACT_EN defined:
  - Sub port exists.
  - Subtract uses inverted op_b nibbles and initial carry_r=1.
- SUBTRACT_EN undefined:
  - No Sub port.
  - Add only; initial carry_r=0; no inverter logic.

## Structure
- Shared package nsa_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - NIBBLE_W=4 constant.
  - A helper function for counter width.
- One natural sub-module: nibble_adder_cin, a 4-bit adder with carry-in and carry-out (dataflow, {Cout, S} = A + B + Cin). The controller instantiates it once.

## Test plan
- WIDTH=16:
  - A=0x1234, B=0x4321 → Result=0x5555, Carry=0.
  - Done_Valid rises exactly 4 cycles after accept.
  - Start_Ready is 0 from accept until the cycle after the handshake.
- Carry ripple: A=0xFFFF, B=0x0001 → Result=0x0000, Carry=1. Checks carry propagating through all 4 nibble steps.
- SUBTRACT_EN (each case under Sub=1):
  - A=0x0005, B=0x0007 → Result=0xFFFE, Carry=0.
  - A=0x0007, B=0x0005 → Result=0x0002, Carry=1.
- Backpressure and ignored requests:
  - Hold Done_Ready=0 for 3 cycles in DONE → Result/Carry/Done_Valid unchanged.
  - Drive Start_Valid=1 with new operands during RUN/DONE → ignored; the following operation uses only operands presented in IDLE.
- Reset mid-operation:
  - Assert Rst at the 2nd RUN cycle of 0xAAAA+0x5555 → next cycle state IDLE, Result=0, Carry=0, Done_Valid=0, Start_Ready=1.
  - A subsequent 0x0001+0x0001 → 0x0002.
- WIDTH=4 (NIB=1): A=0x9, B=0x8 → Result=0x1, Carry=1, Done_Valid 1 cycle after accept.
